// File: rtl/c3lib_strap_pkg.sv
// Shared types and sizing helpers for the strap capture block.
package c3lib_strap_pkg;

  typedef enum logic [1:0] {SETTLE, CONFIRM, DONE} strap_state_e;

  // Bits needed to hold values 0..maxv, one spare so terminal compares never wrap.
  function automatic int cnt_w(input int maxv);
    return $clog2(maxv) + 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/c3lib_strap_stab_cnt.sv
// Settle/confirm counter, reference sample and retry tracking. Reports
// settle completion, stability, mismatch and retry exhaustion to the FSM.
module c3lib_strap_stab_cnt
  import c3lib_strap_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SETTLE_CYC  = 16,
  parameter int CONFIRM_CNT = 4,
  parameter int MAX_RETRY   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  strap_state_e       state,
  input  logic [WIDTH-1:0]   strap_in,
  output logic [WIDTH-1:0]   ref_val,
  output logic               settle_done,
  output logic               stable,
  output logic               mismatch,
  output logic               retry_exhausted
);

  localparam int CW = cnt_w(max2(SETTLE_CYC - 1, CONFIRM_CNT - 2));
  localparam int RW = cnt_w(MAX_RETRY);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] CONFIRM_LAST = CW'(CONFIRM_CNT - 2);
  localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRY);

  logic [CW-1:0] cnt;
  logic [RW-1:0] retry;
  logic          match;

  assign match           = (strap_in == ref_val);
  assign settle_done     = (state == SETTLE) && (cnt == SETTLE_LAST);
  assign stable          = (state == CONFIRM) && match && (cnt == CONFIRM_LAST);
  assign mismatch        = (state == CONFIRM) && !match;
  assign retry_exhausted = mismatch && (retry == RETRY_LAST);

  // Counter/ref/retry update; every counter stops at its terminal compare.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      retry   <= '0;
      ref_val <= '0;
    end else if (clr) begin
      cnt   <= '0;
      retry <= '0;
    end else begin
      case (state)
        SETTLE: begin
          if (settle_done) begin
            cnt     <= '0;
            ref_val <= strap_in;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CONFIRM: begin
          if (mismatch) begin
            ref_val <= strap_in;
            cnt     <= '0;
            if (!retry_exhausted) retry <= retry + 1'b1;
          end else if (!stable) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/c3lib_mtie_strap_capture.sv
// Captures metal-tie strap outputs after reset: settle, confirm stability,
// latch a validated word; supports 4-phase recapture.
// Optional macro C3LIB_STRAP_OVRD_EN adds ovrd_en/ovrd_val output override.
module c3lib_mtie_strap_capture
  import c3lib_strap_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               SETTLE_CYC  = 16,
  parameter int               CONFIRM_CNT = 4,
  parameter int               MAX_RETRY   = 3,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef C3LIB_STRAP_OVRD_EN
  input  logic             ovrd_en,
  input  logic [WIDTH-1:0] ovrd_val,
`endif
  input  logic [WIDTH-1:0] strap_in,
  input  logic             recap_req,
  output logic             recap_ack,
  output logic [WIDTH-1:0] strap_q,
  output logic             strap_vld,
  output logic             strap_err
);

  strap_state_e     state_q, state_d;
  logic [WIDTH-1:0] cap_q, cap_q_d, ref_val;
  logic             cap_vld, cap_vld_d, cap_err, cap_err_d;
  logic             ack_q, ack_d, busy_q, busy_d, clr;
  logic             settle_done, stable, mismatch, retry_exhausted;

  c3lib_strap_stab_cnt #(
    .WIDTH(WIDTH), .SETTLE_CYC(SETTLE_CYC),
    .CONFIRM_CNT(CONFIRM_CNT), .MAX_RETRY(MAX_RETRY)
  ) u_stab (
    .clk(clk), .rst_n(rst_n), .clr(clr), .state(state_q),
    .strap_in(strap_in), .ref_val(ref_val), .settle_done(settle_done),
    .stable(stable), .mismatch(mismatch), .retry_exhausted(retry_exhausted)
  );

  // Next-state and capture/handshake decode. busy marks a recapture in
  // flight so only its completion raises the acknowledge.
  always_comb begin
    state_d   = state_q;
    cap_q_d   = cap_q;
    cap_vld_d = cap_vld;
    cap_err_d = cap_err;
    ack_d     = ack_q;
    busy_d    = busy_q;
    clr       = 1'b0;
    if (ack_q && !recap_req) ack_d = 1'b0;
    case (state_q)
      SETTLE: if (settle_done) state_d = CONFIRM;
      CONFIRM: begin
        if (stable || retry_exhausted) begin
          cap_q_d   = stable ? ref_val : strap_in;
          cap_vld_d = 1'b1;
          cap_err_d = !stable;
          state_d   = DONE;
          busy_d    = 1'b0;
          if (busy_q) ack_d = 1'b1;
        end
      end
      DONE: begin
        if (recap_req && !ack_q) begin
          state_d   = SETTLE;
          cap_vld_d = 1'b0;
          cap_err_d = 1'b0;
          busy_d    = 1'b1;
          clr       = 1'b1;
        end
      end
      default: state_d = SETTLE;
    endcase
  end

  // FSM and capture registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SETTLE;
      cap_q   <= RESET_VAL;
      cap_vld <= 1'b0;
      cap_err <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_q_d;
      cap_vld <= cap_vld_d;
      cap_err <= cap_err_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign recap_ack = ack_q;

`ifdef C3LIB_STRAP_OVRD_EN
  logic [WIDTH-1:0] out_q;
  logic             out_vld, out_err;

  // Override output stage: follows the FSM's next values so releasing the
  // override restores the held capture on the following edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q   <= RESET_VAL;
      out_vld <= 1'b0;
      out_err <= 1'b0;
    end else if (ovrd_en) begin
      out_q   <= ovrd_val;
      out_vld <= 1'b1;
      out_err <= 1'b0;
    end else begin
      out_q   <= cap_q_d;
      out_vld <= cap_vld_d;
      out_err <= cap_err_d;
    end
  end

  assign strap_q   = out_q;
  assign strap_vld = out_vld;
  assign strap_err = out_err;
`else
  assign strap_q   = cap_q;
  assign strap_vld = cap_vld;
  assign strap_err = cap_err;
`endif

endmodule

// File: tb/tb_c3lib_mtie_strap_capture.sv
// Directed self-checking bench for c3lib_mtie_strap_capture (default params).
// Override scenario is built when C3LIB_STRAP_OVRD_EN is defined.
module tb_c3lib_mtie_strap_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] strap_in = 8'h00;
  logic       recap_req = 1'b0;
  logic       recap_ack, strap_vld, strap_err;
  logic [7:0] strap_q;
`ifdef C3LIB_STRAP_OVRD_EN
  logic       ovrd_en = 1'b0;
  logic [7:0] ovrd_val = 8'h00;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  c3lib_mtie_strap_capture dut (
    .clk(clk), .rst_n(rst_n),
`ifdef C3LIB_STRAP_OVRD_EN
    .ovrd_en(ovrd_en), .ovrd_val(ovrd_val),
`endif
    .strap_in(strap_in), .recap_req(recap_req), .recap_ack(recap_ack),
    .strap_q(strap_q), .strap_vld(strap_vld), .strap_err(strap_err)
  );

  // One reset edge, then release; returns at the negedge with 0 edges counted.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    strap_in = 8'hA5;
    recap_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (strap_q !== 8'h00) begin n_fail++; $display("FAIL reset_q got %h exp 00", strap_q); end
    n_checks++; if (strap_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %b exp 0", strap_vld); end
    n_checks++; if (strap_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", strap_err); end
    n_checks++; if (recap_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b exp 0", recap_ack); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    strap_in = 8'hA5;
    do_reset();
    step(18);
    n_checks++; if (strap_vld !== 1'b0) begin n_fail++; $display("FAIL basic_vld_e18 got %b exp 0", strap_vld); end
    step(1);
    n_checks++; if (strap_vld !== 1'b1) begin n_fail++; $display("FAIL basic_vld_e19 got %b exp 1", strap_vld); end
    n_checks++; if (strap_q !== 8'hA5) begin n_fail++; $display("FAIL basic_q got %h exp a5", strap_q); end
    n_checks++; if (strap_err !== 1'b0) begin n_fail++; $display("FAIL basic_err got %b exp 0", strap_err); end
  endtask

  // ref=FF at edge 16, then mismatches at edges 17..20; the 4th one errors out.
  task automatic test_toggle();
    strap_in = 8'hFF;
    do_reset();
    step(16);
    for (int e = 17; e <= 20; e++) begin
      strap_in = (e % 2 == 0) ? 8'hFF : 8'h00;
      step(1);
      if (e == 19) begin
        n_checks++; if (strap_vld !== 1'b0) begin n_fail++; $display("FAIL toggle_vld_e19 got %b exp 0", strap_vld); end
      end
    end
    n_checks++; if (strap_vld !== 1'b1) begin n_fail++; $display("FAIL toggle_vld got %b exp 1", strap_vld); end
    n_checks++; if (strap_err !== 1'b1) begin n_fail++; $display("FAIL toggle_err got %b exp 1", strap_err); end
    n_checks++; if (strap_q !== 8'hFF) begin n_fail++; $display("FAIL toggle_q got %h exp ff", strap_q); end
    strap_in = 8'h12;
    step(3);
    n_checks++; if (strap_q !== 8'hFF) begin n_fail++; $display("FAIL toggle_hold_q got %h exp ff", strap_q); end
  endtask

  // Glitch at edge 17 plus the return at 18 cost two restarts: vld at edge 21.
  task automatic test_glitch();
    strap_in = 8'hA5;
    do_reset();
    step(16);
    strap_in = 8'h5A;
    step(1);
    strap_in = 8'hA5;
    step(3);
    n_checks++; if (strap_vld !== 1'b0) begin n_fail++; $display("FAIL glitch_vld_e20 got %b exp 0", strap_vld); end
    step(1);
    n_checks++; if (strap_vld !== 1'b1) begin n_fail++; $display("FAIL glitch_vld_e21 got %b exp 1", strap_vld); end
    n_checks++; if (strap_q !== 8'hA5) begin n_fail++; $display("FAIL glitch_q got %h exp a5", strap_q); end
    n_checks++; if (strap_err !== 1'b0) begin n_fail++; $display("FAIL glitch_err got %b exp 0", strap_err); end
  endtask

  // Starts in DONE holding A5.
  task automatic test_recapture();
    strap_in = 8'h3C;
    recap_req = 1'b1;
    step(1);
    n_checks++; if (strap_vld !== 1'b0) begin n_fail++; $display("FAIL recap_vld_drop got %b exp 0", strap_vld); end
    n_checks++; if (recap_ack !== 1'b0) begin n_fail++; $display("FAIL recap_ack_early got %b exp 0", recap_ack); end
    step(18);
    n_checks++; if (strap_q !== 8'hA5) begin n_fail++; $display("FAIL recap_q_hold got %h exp a5", strap_q); end
    n_checks++; if (strap_vld !== 1'b0) begin n_fail++; $display("FAIL recap_vld_e18 got %b exp 0", strap_vld); end
    step(1);
    n_checks++; if (strap_vld !== 1'b1) begin n_fail++; $display("FAIL recap_vld_e19 got %b exp 1", strap_vld); end
    n_checks++; if (recap_ack !== 1'b1) begin n_fail++; $display("FAIL recap_ack_rise got %b exp 1", recap_ack); end
    n_checks++; if (strap_q !== 8'h3C) begin n_fail++; $display("FAIL recap_q got %h exp 3c", strap_q); end
    step(2);
    n_checks++; if (recap_ack !== 1'b1 || strap_vld !== 1'b1) begin n_fail++; $display("FAIL recap_ack_hold got ack=%b vld=%b exp 1 1", recap_ack, strap_vld); end
    recap_req = 1'b0;
    step(1);
    n_checks++; if (recap_ack !== 1'b0) begin n_fail++; $display("FAIL recap_ack_drop got %b exp 0", recap_ack); end
    n_checks++; if (strap_vld !== 1'b1) begin n_fail++; $display("FAIL recap_vld_after got %b exp 1", strap_vld); end
  endtask

  task automatic test_reset_mid();
    strap_in = 8'hA5;
    do_reset();
    step(17);
    rst_n = 1'b0;
    step(1);
    n_checks++; if (strap_q !== 8'h00 || strap_vld !== 1'b0 || strap_err !== 1'b0 || recap_ack !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outs got q=%h vld=%b err=%b ack=%b exp 00 0 0 0", strap_q, strap_vld, strap_err, recap_ack);
    end
    rst_n = 1'b1;
    step(18);
    n_checks++; if (strap_vld !== 1'b0) begin n_fail++; $display("FAIL midrst_vld_e18 got %b exp 0", strap_vld); end
    step(1);
    n_checks++; if (strap_vld !== 1'b1 || strap_q !== 8'hA5) begin n_fail++; $display("FAIL midrst_e19 got vld=%b q=%h exp 1 a5", strap_vld, strap_q); end
  endtask

  // Request held from reset: accepted on DONE entry, ack after the next capture.
  task automatic test_pending();
    strap_in = 8'h77;
    recap_req = 1'b1;
    do_reset();
    step(19);
    n_checks++; if (strap_vld !== 1'b1 || recap_ack !== 1'b0) begin n_fail++; $display("FAIL pend_first got vld=%b ack=%b exp 1 0", strap_vld, recap_ack); end
    step(1);
    n_checks++; if (strap_vld !== 1'b0) begin n_fail++; $display("FAIL pend_accept got %b exp 0", strap_vld); end
    step(18);
    n_checks++; if (recap_ack !== 1'b0) begin n_fail++; $display("FAIL pend_ack_early got %b exp 0", recap_ack); end
    step(1);
    n_checks++; if (strap_vld !== 1'b1 || recap_ack !== 1'b1) begin n_fail++; $display("FAIL pend_done got vld=%b ack=%b exp 1 1", strap_vld, recap_ack); end
    recap_req = 1'b0;
    step(1);
  endtask

`ifdef C3LIB_STRAP_OVRD_EN
  task automatic test_override();
    strap_in = 8'h5A;
    do_reset();
    step(3);
    ovrd_en = 1'b1;
    ovrd_val = 8'h81;
    step(1);
    n_checks++; if (strap_q !== 8'h81 || strap_vld !== 1'b1 || strap_err !== 1'b0) begin
      n_fail++; $display("FAIL ovrd_on got q=%h vld=%b err=%b exp 81 1 0", strap_q, strap_vld, strap_err);
    end
    ovrd_en = 1'b0;
    step(1);
    n_checks++; if (strap_vld !== 1'b0 || strap_q !== 8'h00) begin n_fail++; $display("FAIL ovrd_off got vld=%b q=%h exp 0 00", strap_vld, strap_q); end
    step(13);
    n_checks++; if (strap_vld !== 1'b0) begin n_fail++; $display("FAIL ovrd_vld_e18 got %b exp 0", strap_vld); end
    step(1);
    n_checks++; if (strap_vld !== 1'b1 || strap_q !== 8'h5A) begin n_fail++; $display("FAIL ovrd_fsm_e19 got vld=%b q=%h exp 1 5a", strap_vld, strap_q); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_recapture();
    test_toggle();
    test_glitch();
    test_reset_mid();
    test_pending();
`ifdef C3LIB_STRAP_OVRD_EN
    test_override();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/c3lib_mtie_strap_capture.md
Name: c3lib_mtie_strap_capture

Overview:
- Consumer side of metal-programmable tie cells (mtie0/mtie1 banks).
- Receives a bus of tie outputs after reset release and waits a settle window.
- Confirms the bus is stable over consecutive samples, then latches it as a validated strap word for downstream configuration logic.
- Supports a 4-phase recapture handshake and flags straps that never stabilise.

Parameters:
- WIDTH, 8: number of strap bits.
- SETTLE_CYC, 16: cycles waited after reset release before sampling; must be ≥1.
- CONFIRM_CNT, 4: consecutive identical samples required, reference sample included; must be ≥2.
- MAX_RETRY, 3: mismatch restarts allowed before the error exit.
- RESET_VAL, {WIDTH{1'b0}}: strap_q value held during reset.

Ports:
- clk  input  1  block clock.
- rst_n  input  1  synchronous, active-low reset.
- strap_in  input  WIDTH  raw tie-cell outputs; quasi-static, treated as synchronous.
- recap_req  input  1  recapture request, level, 4-phase.
- recap_ack  output  1  recapture acknowledge, level.
- strap_q  output  WIDTH  validated strap word.
- strap_vld  output  1  strap_q is valid.
- strap_err  output  1  stability not reached within MAX_RETRY restarts.

Behaviour:
- Reset (rst_n=0 sampled at clk edge):
  - Outputs: strap_q=RESET_VAL, strap_vld=0, strap_err=0, recap_ack=0.
  - Internal: state=SETTLE, cnt=0, retry=0, ref=0.
- FSM states: SETTLE, CONFIRM, DONE.
- SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE_CYC-1: next state CONFIRM, cnt<=0, ref<=strap_in captured on the transition edge.
- CONFIRM, each cycle compare strap_in to ref:
  - Match: cnt increments. When cnt==CONFIRM_CNT-2 and matching, next edge gives strap_q<=ref, strap_vld<=1, state DONE.
  - Mismatch: ref<=strap_in, cnt<=0, retry increments.
  - Mismatch when retry==MAX_RETRY: strap_q<=strap_in, strap_vld<=1, strap_err<=1, state DONE.
- Latency: with stable input, strap_vld rises on the edge SETTLE_CYC+CONFIRM_CNT-1 cycles after the first cycle with rst_n=1. That is exactly 19 cycles for the defaults; the first high sample is in cycle 19.
- DONE:
  - Outputs are held.
  - A rising recap_req with recap_ack=0 is accepted. Next edge: strap_vld<=0, strap_err<=0, retry<=0, cnt<=0, state SETTLE. strap_q keeps its old value until re-validated.
  - Re-validation sets strap_vld=1 and recap_ack=1 on the same edge.
  - recap_ack stays 1 while recap_req=1 and drops the edge after recap_req=0.
  - A new request is accepted only when recap_req=1 and recap_ack=0.
- recap_req=1 outside DONE: held pending and accepted on DONE entry. recap_ack then rises only at the end of the following capture.
- Counter widths: $clog2 of the relevant maximum +1. No wrap is possible: counters saturate at their terminal compare.
- Reset mid-capture aborts immediately to reset values; no partial strap_q update.
- strap_q never changes while strap_vld=1, except under the override feature.

Optional Feature:
- Macro: C3LIB_STRAP_OVRD_EN.
- Defined:
  - Adds ports ovrd_en (input 1) and ovrd_val (input WIDTH).
  - While ovrd_en=1, strap_q<=ovrd_val and strap_vld<=1 on every edge (1-cycle latency), and strap_err output is forced 0.
  - The FSM keeps running underneath.
  - On ovrd_en falling, the next edge restores the FSM-held capture value and flags.
- Undefined: ports absent, no override mux, no override logic.

Decomposition:
- Shared package c3lib_strap_pkg: state enum (SETTLE, CONFIRM, DONE) and counter-width helper functions.
- One natural sub-module, c3lib_strap_stab_cnt: the compare/ref/cnt/retry logic, reporting stable, mismatch and retry_exhausted to the top FSM.

Test Plan:
- Defaults, strap_in=8'hA5 constant, rst_n released → strap_vld=1 and strap_q=8'hA5 on edge 19, strap_err=0.
- strap_in toggles 8'h00/8'hFF every cycle through CONFIRM → after the 4th mismatch, strap_vld=1, strap_err=1, strap_q=last sampled value.
- One glitch 8'hA5→8'h5A→8'hA5 in CONFIRM → two restarts, final strap_q=8'hA5, strap_err=0, vld delayed by restart cycles.
- In DONE, change strap_in to 8'h3C, raise recap_req → vld drops next edge, strap_q holds 8'hA5 during recapture, then vld, ack=1, strap_q=8'h3C 19 cycles later; drop req → ack=0 next edge.
- rst_n low for 1 cycle mid-CONFIRM → all outputs return to reset values, full 19-cycle capture restarts.
- With C3LIB_STRAP_OVRD_EN: ovrd_en=1, ovrd_val=8'h81 during SETTLE → strap_q=8'h81, vld=1 next edge; release → vld=0 until FSM completes.
